uart_framed: RTL and testbench

Parametrised successor to the existing FIFO-buffered UART. It keeps the full-bit `baud_div` timing and the toggle-strobe host handshakes, and adds:
- compile-time data width and independent TX/RX FIFO depths;
- run-time parity and stop-bit selection;
- per-byte receive error flags, sticky overrun, and FIFO fill levels.

It sits between the host register/bus logic and the serial pins, and may be looped back TX→RX for self-test.

---
 rtl/uart_framed.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_framed.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_framed.sv
// FIFO-buffered UART with compile-time data width and FIFO depths, run-time parity/stop selection.
// Host handshakes are toggle strobes; each received entry carries {parity_err, frame_err}.
module uart_framed #(
   parameter int DATA_BITS     = 8,
   parameter int TX_FIFO_DEPTH = 64,
   parameter int RX_FIFO_DEPTH = 64
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [15:0]                      baud_div,
   input  logic [1:0]                       cfg_parity,
   input  logic                             cfg_stop2,
   input  logic                             uart_tx_start,
   input  logic [DATA_BITS-1:0]             uart_tx_data_in,
   output logic                             uart_tx_pin,
   output logic                             uart_tx_fifo_full,
   output logic                             uart_tx_fifo_empty,
   output logic [$clog2(TX_FIFO_DEPTH):0]   uart_tx_level,
   input  logic                             uart_rx_pin,
   input  logic                             uart_rx_read,
   output logic                             uart_rx_ready,
   output logic [DATA_BITS-1:0]             uart_rx_byte,
   output logic [1:0]                       uart_rx_err,
   output logic [$clog2(RX_FIFO_DEPTH):0]   uart_rx_level,
   output logic                             uart_rx_overrun,
   input  logic                             err_clear
);
   localparam int TAW = $clog2(TX_FIFO_DEPTH);
   localparam int RAW = $clog2(RX_FIFO_DEPTH);
   localparam logic [2:0]   LAST_BIT    = 3'(DATA_BITS - 1);
   localparam logic [TAW:0] TX_FULL_LVL = (TAW + 1)'(TX_FIFO_DEPTH);
   localparam logic [RAW:0] RX_FULL_LVL = (RAW + 1)'(RX_FIFO_DEPTH);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP1, TX_STOP2} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HI} rx_state_t;

   logic [DATA_BITS-1:0] tx_mem [TX_FIFO_DEPTH];
   logic [TAW:0]         tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d, tx_level_q, tx_level_d;
   logic                 tx_full_q, tx_full_d, tx_empty_q, tx_empty_d, tx_tog_q, tx_push, tx_pop;
   logic [DATA_BITS-1:0] tx_head;
   tx_state_t            tx_state_q, tx_state_d;
   logic [15:0]          tx_cnt_q, tx_cnt_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
   logic [2:0]           tx_bit_q, tx_bit_d;
   logic                 tx_par_q, tx_par_d, tx_paren_q, tx_paren_d, tx_stop2_q, tx_stop2_d;
   logic                 tx_pin_q, tx_pin_d, tx_load;

   logic [DATA_BITS+1:0] rx_mem [RX_FIFO_DEPTH];
   logic [RAW:0]         rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d, rx_level_q, rx_level_d;
   logic                 rx_full_q, rx_full_d, rx_empty_q, rx_empty_d, rx_tog_q, rx_push, rx_pop;
   logic                 rx_s1_q, rx_s2_q, rx_s3_q, rx_push_req, rx_ferr, rx_ovr_q, rx_ovr_d;
   rx_state_t            rx_state_q, rx_state_d;
   logic [15:0]          rx_cnt_q, rx_cnt_d;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d;
   logic [2:0]           rx_bit_q, rx_bit_d;
   logic                 rx_paren_q, rx_paren_d, rx_odd_q, rx_odd_d, rx_perr_q, rx_perr_d;
   logic [1:0]           rx_err_q, rx_err_d;

   // Pointers are one bit wider than the address, so the level is a plain difference.
   always_comb begin
      tx_push    = (uart_tx_start ^ tx_tog_q) & ~tx_full_q;
      tx_wptr_d  = tx_wptr_q + {{TAW{1'b0}}, tx_push};
      tx_rptr_d  = tx_rptr_q + {{TAW{1'b0}}, tx_pop};
      tx_level_d = tx_wptr_d - tx_rptr_d;
      tx_full_d  = (tx_level_d == TX_FULL_LVL);
      tx_empty_d = (tx_level_d == '0);
      tx_head    = tx_mem[tx_rptr_q[TAW-1:0]];
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q - 16'd1;
      tx_sh_d    = tx_sh_q;
      tx_bit_d   = tx_bit_q;
      tx_par_d   = tx_par_q;
      tx_paren_d = tx_paren_q;
      tx_stop2_d = tx_stop2_q;
      tx_load    = 1'b0;
      tx_pop     = 1'b0;
      case (tx_state_q)
         TX_IDLE:  tx_load = ~tx_empty_q;
         TX_START: if (tx_cnt_q == '0) begin
            tx_state_d = TX_DATA;
            tx_cnt_d   = baud_div - 16'd1;
            tx_bit_d   = '0;
         end
         TX_DATA: if (tx_cnt_q == '0) begin
            tx_cnt_d = baud_div - 16'd1;
            if (tx_bit_q == LAST_BIT) begin
               tx_state_d = tx_paren_q ? TX_PAR : TX_STOP1;
            end else begin
               tx_bit_d = tx_bit_q + 3'd1;
               tx_sh_d  = tx_sh_q >> 1;
            end
         end
         TX_PAR: if (tx_cnt_q == '0) begin
            tx_state_d = TX_STOP1;
            tx_cnt_d   = baud_div - 16'd1;
         end
         TX_STOP1: if (tx_cnt_q == '0) begin
            tx_cnt_d = baud_div - 16'd1;
            if (tx_stop2_q) begin
               tx_state_d = TX_STOP2;
            end else begin
               tx_state_d = TX_IDLE;
               tx_load    = ~tx_empty_q;
            end
         end
         TX_STOP2: if (tx_cnt_q == '0) begin
            tx_state_d = TX_IDLE;
            tx_load    = ~tx_empty_q;
         end
         default: tx_state_d = TX_IDLE;
      endcase
      // Popping on the last stop tick chains frames with no idle bit in between.
      if (tx_load) begin
         tx_pop     = 1'b1;
         tx_state_d = TX_START;
         tx_cnt_d   = baud_div - 16'd1;
         tx_sh_d    = tx_head;
         tx_paren_d = cfg_parity[0] ^ cfg_parity[1];
         tx_par_d   = (^tx_head) ^ cfg_parity[1];
         tx_stop2_d = cfg_stop2;
      end
      case (tx_state_d)
         TX_START: tx_pin_d = 1'b0;
         TX_DATA:  tx_pin_d = tx_sh_d[0];
         TX_PAR:   tx_pin_d = tx_par_d;
         default:  tx_pin_d = 1'b1;
      endcase
   end

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q - 16'd1;
      rx_sh_d     = rx_sh_q;
      rx_bit_d    = rx_bit_q;
      rx_paren_d  = rx_paren_q;
      rx_odd_d    = rx_odd_q;
      rx_perr_d   = rx_perr_q;
      rx_push_req = 1'b0;
      rx_ferr     = 1'b0;
      case (rx_state_q)
         RX_IDLE: if (!rx_s2_q && rx_s3_q) begin
            rx_state_d = RX_START;
            rx_cnt_d   = (baud_div >> 1) - 16'd1;
            rx_paren_d = cfg_parity[0] ^ cfg_parity[1];
            rx_odd_d   = cfg_parity[1];
         end
         RX_START: if (rx_cnt_q == '0) begin
            rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            rx_cnt_d   = baud_div - 16'd1;
            rx_bit_d   = '0;
            rx_perr_d  = 1'b0;
         end
         RX_DATA: if (rx_cnt_q == '0) begin
            rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
            rx_cnt_d = baud_div - 16'd1;
            if (rx_bit_q == LAST_BIT) rx_state_d = rx_paren_q ? RX_PAR : RX_STOP;
            else                      rx_bit_d   = rx_bit_q + 3'd1;
         end
         RX_PAR: if (rx_cnt_q == '0) begin
            rx_perr_d  = (^rx_sh_q) ^ rx_s2_q ^ rx_odd_q;
            rx_state_d = RX_STOP;
            rx_cnt_d   = baud_div - 16'd1;
         end
         RX_STOP: if (rx_cnt_q == '0) begin
            rx_push_req = 1'b1;
            rx_ferr     = ~rx_s2_q;
            rx_state_d  = rx_s2_q ? RX_IDLE : RX_WAIT_HI;
         end
         RX_WAIT_HI: if (rx_s2_q) rx_state_d = RX_IDLE;
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_push    = rx_push_req & ~rx_full_q;
      rx_pop     = (uart_rx_read ^ rx_tog_q) & ~rx_empty_q;
      rx_wptr_d  = rx_wptr_q + {{RAW{1'b0}}, rx_push};
      rx_rptr_d  = rx_rptr_q + {{RAW{1'b0}}, rx_pop};
      rx_level_d = rx_wptr_d - rx_rptr_d;
      rx_full_d  = (rx_level_d == RX_FULL_LVL);
      rx_empty_d = (rx_level_d == '0);
      rx_ovr_d   = (rx_push_req & rx_full_q) | (rx_ovr_q & ~err_clear);
      {rx_err_d, rx_byte_d} = rx_pop ? rx_mem[rx_rptr_q[RAW-1:0]] : {rx_err_q, rx_byte_q};
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wptr_q[TAW-1:0]] <= uart_tx_data_in;
      if (rx_push) rx_mem[rx_wptr_q[RAW-1:0]] <= {rx_perr_q, rx_ferr, rx_sh_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wptr_q <= '0; tx_rptr_q <= '0; tx_level_q <= '0;
         tx_full_q <= 1'b0; tx_empty_q <= 1'b1; tx_tog_q <= 1'b0;
         tx_state_q <= TX_IDLE; tx_cnt_q <= '0; tx_sh_q <= '0; tx_bit_q <= '0;
         tx_par_q <= 1'b0; tx_paren_q <= 1'b0; tx_stop2_q <= 1'b0; tx_pin_q <= 1'b1;
         rx_wptr_q <= '0; rx_rptr_q <= '0; rx_level_q <= '0;
         rx_full_q <= 1'b0; rx_empty_q <= 1'b1; rx_tog_q <= 1'b0; rx_ovr_q <= 1'b0;
         rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_s3_q <= 1'b1;
         rx_state_q <= RX_IDLE; rx_cnt_q <= '0; rx_sh_q <= '0; rx_bit_q <= '0;
         rx_paren_q <= 1'b0; rx_odd_q <= 1'b0; rx_perr_q <= 1'b0;
         rx_byte_q <= '0; rx_err_q <= '0;
      end else begin
         tx_wptr_q <= tx_wptr_d; tx_rptr_q <= tx_rptr_d; tx_level_q <= tx_level_d;
         tx_full_q <= tx_full_d; tx_empty_q <= tx_empty_d; tx_tog_q <= uart_tx_start;
         tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_sh_q <= tx_sh_d; tx_bit_q <= tx_bit_d;
         tx_par_q <= tx_par_d; tx_paren_q <= tx_paren_d; tx_stop2_q <= tx_stop2_d; tx_pin_q <= tx_pin_d;
         rx_wptr_q <= rx_wptr_d; rx_rptr_q <= rx_rptr_d; rx_level_q <= rx_level_d;
         rx_full_q <= rx_full_d; rx_empty_q <= rx_empty_d; rx_tog_q <= uart_rx_read; rx_ovr_q <= rx_ovr_d;
         rx_s1_q <= uart_rx_pin; rx_s2_q <= rx_s1_q; rx_s3_q <= rx_s2_q;
         rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_sh_q <= rx_sh_d; rx_bit_q <= rx_bit_d;
         rx_paren_q <= rx_paren_d; rx_odd_q <= rx_odd_d; rx_perr_q <= rx_perr_d;
         rx_byte_q <= rx_byte_d; rx_err_q <= rx_err_d;
      end
   end

   assign uart_tx_pin        = tx_pin_q;
   assign uart_tx_fifo_full  = tx_full_q;
   assign uart_tx_fifo_empty = tx_empty_q;
   assign uart_tx_level      = tx_level_q;
   assign uart_rx_ready      = ~rx_empty_q;
   assign uart_rx_byte       = rx_byte_q;
   assign uart_rx_err        = rx_err_q;
   assign uart_rx_level      = rx_level_q;
   assign uart_rx_overrun    = rx_ovr_q;
endmodule

// File: tb/tb_uart_framed.sv
// Bench for uart_framed: 8-bit loopback instance plus a 5-bit, depth-4 instance.
module tb_uart_framed;
   localparam int BAUD  = 16;
   localparam int LIMIT = 20000;

   typedef struct {
      logic [7:0] data;
      logic [1:0] par;
      logic       s2;
      logic       has_par;
      logic       exp_pbit;
      int         exp_len;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, rst5_n, err_clear, cfg_stop2;
   logic [15:0] baud_div;
   logic [1:0]  cfg_parity;

   logic       tx_start, tx_pin, tx_full, tx_empty, rx_pin, rx_read, rx_ready, rx_ovr, lb, rx_drv;
   logic [7:0] tx_data, rx_byte;
   logic [6:0] tx_level, rx_level;
   logic [1:0] rx_err;

   logic       t5_start, t5_pin, t5_full, t5_empty, r5_read, r5_ready, r5_ovr;
   logic [4:0] t5_data, r5_byte;
   logic [2:0] t5_level, r5_level;
   logic [1:0] r5_err;

   logic cap_sel, cap_pin;
   assign rx_pin  = lb ? tx_pin : rx_drv;
   assign cap_pin = cap_sel ? t5_pin : tx_pin;

   uart_framed dut (
      .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
      .uart_tx_start(tx_start), .uart_tx_data_in(tx_data), .uart_tx_pin(tx_pin),
      .uart_tx_fifo_full(tx_full), .uart_tx_fifo_empty(tx_empty), .uart_tx_level(tx_level),
      .uart_rx_pin(rx_pin), .uart_rx_read(rx_read), .uart_rx_ready(rx_ready),
      .uart_rx_byte(rx_byte), .uart_rx_err(rx_err), .uart_rx_level(rx_level),
      .uart_rx_overrun(rx_ovr), .err_clear(err_clear)
   );

   uart_framed #(.DATA_BITS(5), .TX_FIFO_DEPTH(4), .RX_FIFO_DEPTH(4)) dut5 (
      .clk(clk), .rst_n(rst5_n), .baud_div(baud_div), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
      .uart_tx_start(t5_start), .uart_tx_data_in(t5_data), .uart_tx_pin(t5_pin),
      .uart_tx_fifo_full(t5_full), .uart_tx_fifo_empty(t5_empty), .uart_tx_level(t5_level),
      .uart_rx_pin(t5_pin), .uart_rx_read(r5_read), .uart_rx_ready(r5_ready),
      .uart_rx_byte(r5_byte), .uart_rx_err(r5_err), .uart_rx_level(r5_level),
      .uart_rx_overrun(r5_ovr), .err_clear(err_clear)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic send_tx(input logic [7:0] d);
      tx_data  = d;
      tx_start = ~tx_start;
      @(negedge clk);
   endtask

   task automatic send5(input logic [4:0] d);
      t5_data  = d;
      t5_start = ~t5_start;
      @(negedge clk);
   endtask

   task automatic rx_pop();
      rx_read = ~rx_read;
      @(negedge clk);
   endtask

   task automatic wait_rx_level(input int n, input string nm);
      int k = 0;
      while (rx_level != n && k < LIMIT) begin
         @(negedge clk);
         k++;
      end
      check(nm, 32'(rx_level), 32'(n));
   endtask

   task automatic send_wire(input logic [7:0] d, input logic hp, input logic pb, input logic stop_v);
      rx_drv = 1'b0;
      repeat (BAUD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         repeat (BAUD) @(negedge clk);
      end
      if (hp) begin
         rx_drv = pb;
         repeat (BAUD) @(negedge clk);
      end
      rx_drv = stop_v;
      repeat (BAUD) @(negedge clk);
      rx_drv = 1'b1;
      repeat (2 * BAUD) @(negedge clk);
   endtask

   // Samples one frame at bit centres and times start-to-start against the following frame.
   task automatic capture(input int nb, input logic hp, input logic s2, output logic [7:0] d,
                          output logic p, output logic shape_ok, output int len);
      int n;
      int t0;
      d = '0; p = 1'b0; shape_ok = 1'b1; len = 0;
      n = 0;
      while (cap_pin !== 1'b0 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check("cap_first_start", 32'(cap_pin), 32'd0);
      t0 = cyc;
      repeat (BAUD / 2) @(negedge clk);
      if (cap_pin !== 1'b0) shape_ok = 1'b0;
      for (int i = 0; i < nb; i++) begin
         repeat (BAUD) @(negedge clk);
         d[i] = cap_pin;
      end
      if (hp) begin
         repeat (BAUD) @(negedge clk);
         p = cap_pin;
      end
      repeat (BAUD) @(negedge clk);
      if (cap_pin !== 1'b1) shape_ok = 1'b0;
      if (s2) begin
         repeat (BAUD) @(negedge clk);
         if (cap_pin !== 1'b1) shape_ok = 1'b0;
      end
      n = 0;
      while (cap_pin !== 1'b0 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check("cap_second_start", 32'(cap_pin), 32'd0);
      len = cyc - t0;
   endtask

   initial begin : main
      vec_t       vecs[6];
      logic [7:0] cd;
      logic       cp, shape;
      int         len, k;

      vecs[0] = '{8'h07, 2'b01, 1'b0, 1'b1, 1'b1, 11 * BAUD};
      vecs[1] = '{8'hA5, 2'b10, 1'b1, 1'b1, 1'b1, 12 * BAUD};
      vecs[2] = '{8'h3C, 2'b00, 1'b1, 1'b0, 1'b0, 11 * BAUD};
      vecs[3] = '{8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 10 * BAUD};
      vecs[4] = '{8'h80, 2'b01, 1'b0, 1'b1, 1'b1, 11 * BAUD};
      vecs[5] = '{8'h00, 2'b10, 1'b0, 1'b1, 1'b1, 11 * BAUD};

      rst_n = 1'b0; rst5_n = 1'b0; err_clear = 1'b0; baud_div = 16'(BAUD);
      cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      tx_start = 1'b0; tx_data = '0; rx_read = 1'b0; lb = 1'b1; rx_drv = 1'b1;
      t5_start = 1'b0; t5_data = '0; r5_read = 1'b0; cap_sel = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1; rst5_n = 1'b1;
      @(negedge clk);
      check("rst_tx_pin", 32'(tx_pin), 32'd1);
      check("rst_tx_empty", 32'(tx_empty), 32'd1);
      check("rst_tx_full", 32'(tx_full), 32'd0);
      check("rst_rx_ready", 32'(rx_ready), 32'd0);
      check("rst_tx_level", 32'(tx_level), 32'd0);
      check("rst_rx_level", 32'(rx_level), 32'd0);
      check("rst_rx_byte", 32'(rx_byte), 32'd0);
      check("rst_rx_err", 32'(rx_err), 32'd0);
      check("rst_overrun", 32'(rx_ovr), 32'd0);

      for (int i = 0; i < 6; i++) begin
         cfg_parity = vecs[i].par;
         cfg_stop2  = vecs[i].s2;
         send_tx(vecs[i].data);
         send_tx(vecs[i].data);
         capture(8, vecs[i].has_par, vecs[i].s2, cd, cp, shape, len);
         check($sformatf("vec%0d_wire_data", i), 32'(cd), 32'(vecs[i].data));
         if (vecs[i].has_par) check($sformatf("vec%0d_parity_bit", i), 32'(cp), 32'(vecs[i].exp_pbit));
         check($sformatf("vec%0d_frame_shape", i), 32'(shape), 32'd1);
         check($sformatf("vec%0d_frame_len", i), 32'(len), 32'(vecs[i].exp_len));
         wait_rx_level(2, $sformatf("vec%0d_rx_level", i));
         for (int j = 0; j < 2; j++) begin
            rx_pop();
            check($sformatf("vec%0d_rx_byte%0d", i, j), 32'(rx_byte), 32'(vecs[i].data));
            check($sformatf("vec%0d_rx_err%0d", i, j), 32'(rx_err), 32'd0);
         end
      end

      lb = 1'b0;
      cfg_parity = 2'b01;
      cfg_stop2  = 1'b0;
      send_wire(8'h07, 1'b1, 1'b0, 1'b1);
      wait_rx_level(1, "perr_level");
      rx_pop();
      check("perr_byte", 32'(rx_byte), 32'h07);
      check("perr_err", 32'(rx_err), 32'h2);

      cfg_parity = 2'b00;
      send_wire(8'h55, 1'b0, 1'b0, 1'b0);
      wait_rx_level(1, "ferr_level");
      rx_pop();
      check("ferr_byte", 32'(rx_byte), 32'h55);
      check("ferr_err", 32'(rx_err), 32'h1);

      rx_drv = 1'b0;
      repeat (BAUD / 4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (3 * BAUD) @(negedge clk);
      check("glitch_level", 32'(rx_level), 32'd0);
      check("glitch_ready", 32'(rx_ready), 32'd0);

      lb = 1'b1;
      for (int i = 0; i <= 8'h40; i++) send_tx(8'(i));
      check("bulk_tx_full", 32'(tx_full), 32'd1);
      check("bulk_tx_level", 32'(tx_level), 32'd64);
      send_tx(8'h41);
      check("bulk_drop_level", 32'(tx_level), 32'd64);
      k = 0;
      while (!tx_empty && k < LIMIT) begin
         @(negedge clk);
         k++;
      end
      check("bulk_tx_drained", 32'(tx_empty), 32'd1);
      repeat (14 * BAUD) @(negedge clk);
      check("bulk_rx_level", 32'(rx_level), 32'd64);
      check("bulk_overrun", 32'(rx_ovr), 32'd1);
      for (int i = 0; i < 64; i++) begin
         rx_pop();
         check($sformatf("bulk_byte%0d", i), 32'(rx_byte), 32'(i));
         check($sformatf("bulk_err%0d", i), 32'(rx_err), 32'd0);
      end
      check("bulk_ready_after", 32'(rx_ready), 32'd0);
      rx_pop();
      check("empty_pop_byte_hold", 32'(rx_byte), 32'h3F);
      check("empty_pop_level", 32'(rx_level), 32'd0);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      check("overrun_cleared", 32'(rx_ovr), 32'd0);

      cap_sel    = 1'b1;
      cfg_parity = 2'b10;
      cfg_stop2  = 1'b1;
      send5(5'h1F);
      send5(5'h1F);
      capture(5, 1'b1, 1'b1, cd, cp, shape, len);
      check("d5_wire_data", 32'(cd), 32'h1F);
      check("d5_parity_bit", 32'(cp), 32'd0);
      check("d5_frame_shape", 32'(shape), 32'd1);
      check("d5_frame_len", 32'(len), 32'(9 * BAUD));
      k = 0;
      while (r5_level != 3'd2 && k < LIMIT) begin
         @(negedge clk);
         k++;
      end
      check("d5_rx_level", 32'(r5_level), 32'd2);
      r5_read = ~r5_read;
      @(negedge clk);
      check("d5_rx_byte", 32'(r5_byte), 32'h1F);
      check("d5_rx_err", 32'(r5_err), 32'd0);

      send5(5'h1F);
      send5(5'h1F);
      k = 0;
      while (t5_pin !== 1'b0 && k < LIMIT) begin
         @(negedge clk);
         k++;
      end
      repeat (BAUD / 2) @(negedge clk);
      check("d5_mid_start_low", 32'(t5_pin), 32'd0);
      check("d5_mid_tx_level", 32'(t5_level), 32'd1);
      #1 rst5_n = 1'b0;
      #1;
      check("d5_rst_pin", 32'(t5_pin), 32'd1);
      check("d5_rst_tx_empty", 32'(t5_empty), 32'd1);
      check("d5_rst_tx_full", 32'(t5_full), 32'd0);
      check("d5_rst_tx_level", 32'(t5_level), 32'd0);
      check("d5_rst_rx_ready", 32'(r5_ready), 32'd0);
      check("d5_rst_rx_level", 32'(r5_level), 32'd0);
      check("d5_rst_rx_byte", 32'(r5_byte), 32'd0);
      check("d5_rst_rx_err", 32'(r5_err), 32'd0);
      check("d5_rst_overrun", 32'(r5_ovr), 32'd0);
      @(negedge clk);
      rst5_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
